// File: rtl/bram_transpose_ctrl.sv
// Tile transpose sequencer: row-major writes into BRAM port A, then column-major
// reads through port B into a 2-entry output FIFO with valid/ready backpressure.
module bram_transpose_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 11,
    parameter int TILE_DIM   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  tile_done,
    output logic [15:0]           tiles_count,
    output logic [ADDR_WIDTH-1:0] addr_a,
    output logic [DATA_WIDTH-1:0] data_in_a,
    output logic                  wen_a,
    output logic                  ren_a,
    output logic [ADDR_WIDTH-1:0] addr_b,
    output logic [DATA_WIDTH-1:0] data_in_b,
    output logic                  wen_b,
    output logic                  ren_b,
    input  logic [DATA_WIDTH-1:0] data_out_b
);
    localparam int CW = (TILE_DIM > 1) ? $clog2(TILE_DIM) : 1;
    localparam logic [CW-1:0]         LAST  = CW'(TILE_DIM - 1);
    localparam logic [CW-1:0]         ONE   = CW'(1);
    localparam logic [ADDR_WIDTH-1:0] DIM_A = ADDR_WIDTH'(TILE_DIM);

    typedef enum logic {LOAD, DRAIN} state_t;
    state_t state, state_next;

    logic [CW-1:0]         wr_row, wr_col, rd_r, rd_c, out_r, out_c;
    logic                  rd_done, in_flight;
    logic [DATA_WIDTH-1:0] fifo_mem [2];
    logic                  fifo_wp, fifo_rp;
    logic [1:0]            fifo_cnt, occupancy;
    logic                  accept, last_in, pop, last_pop;

    assign accept    = in_ready && in_valid;
    assign last_in   = accept && (wr_row == LAST) && (wr_col == LAST);
    assign out_valid = (fifo_cnt != 2'd0);
    assign out_data  = fifo_mem[fifo_rp];
    assign out_last  = out_valid && (out_r == LAST) && (out_c == LAST);
    assign pop       = out_valid && out_ready;
    assign last_pop  = pop && out_last;
    assign tile_done = last_pop;
    assign occupancy = fifo_cnt + {1'b0, in_flight};

    assign wen_a     = accept;
    assign addr_a    = ADDR_WIDTH'(wr_row) * DIM_A + ADDR_WIDTH'(wr_col);
    assign data_in_a = in_data;
    assign ren_a     = 1'b0;
    assign addr_b    = ADDR_WIDTH'(rd_r) * DIM_A + ADDR_WIDTH'(rd_c);
    assign data_in_b = '0;
    assign wen_b     = 1'b0;

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= LOAD;
        else     state <= state_next;
    end

    // NOTE: defaults first in every always_comb so no path leaves a signal unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            LOAD:    if (last_in)  state_next = DRAIN;
            DRAIN:   if (last_pop) state_next = LOAD;
            default: state_next = LOAD;
        endcase
    end

    // A pop in the same cycle frees a slot, which keeps full throughput at two outstanding.
    always_comb begin
        in_ready = 1'b0;
        ren_b    = 1'b0;
        case (state)
            LOAD:    in_ready = 1'b1;
            DRAIN:   ren_b = !rd_done && ((occupancy < 2'd2) || ((occupancy == 2'd2) && pop));
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_row      <= '0;
            wr_col      <= '0;
            rd_r        <= '0;
            rd_c        <= '0;
            rd_done     <= 1'b0;
            out_r       <= '0;
            out_c       <= '0;
            in_flight   <= 1'b0;
            fifo_wp     <= 1'b0;
            fifo_rp     <= 1'b0;
            fifo_cnt    <= 2'd0;
            tiles_count <= 16'd0;
        end else begin
            in_flight <= ren_b;
            if (accept) begin
                if (wr_col == LAST) begin
                    wr_col <= '0;
                    wr_row <= (wr_row == LAST) ? '0 : wr_row + ONE;
                end else begin
                    wr_col <= wr_col + ONE;
                end
            end
            if (ren_b) begin
                if (rd_r == LAST) begin
                    rd_r <= '0;
                    if (rd_c == LAST) begin
                        rd_c    <= '0;
                        rd_done <= 1'b1;
                    end else begin
                        rd_c <= rd_c + ONE;
                    end
                end else begin
                    rd_r <= rd_r + ONE;
                end
            end
            if (in_flight) fifo_wp <= ~fifo_wp;
            if (pop) begin
                fifo_rp <= ~fifo_rp;
                if (out_r == LAST) begin
                    out_r <= '0;
                    out_c <= (out_c == LAST) ? '0 : out_c + ONE;
                end else begin
                    out_r <= out_r + ONE;
                end
            end
            fifo_cnt <= fifo_cnt + {1'b0, in_flight} - {1'b0, pop};
            if (last_pop) begin
                rd_done     <= 1'b0;
                tiles_count <= tiles_count + 16'd1;
            end
        end
    end

    // NOTE: FIFO storage is not reset; fifo_cnt alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (in_flight) fifo_mem[fifo_wp] <= data_out_b;
    end

endmodule

// File: tb/tb_bram_transpose_ctrl.sv
// Bench for bram_transpose_ctrl with N=4: BRAM model, transpose scoreboard and
// per-cycle protocol checks, plus literal expectations for selected tiles.
module tb_bram_transpose_ctrl;
    localparam int DW = 8;
    localparam int AW = 11;
    localparam int N  = 4;
    localparam int NN = N * N;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          tile_done;
    logic [15:0]   tiles_count;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] data_in_a, data_in_b, data_out_b;
    logic          wen_a, ren_a, wen_b, ren_b;

    bram_transpose_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TILE_DIM(N)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .tile_done(tile_done), .tiles_count(tiles_count),
        .addr_a(addr_a), .data_in_a(data_in_a), .wen_a(wen_a), .ren_a(ren_a),
        .addr_b(addr_b), .data_in_b(data_in_b), .wen_b(wen_b), .ren_b(ren_b),
        .data_out_b(data_out_b)
    );

    always #5 clk = ~clk;

    // Behavioural BRAM: write on port A, registered read on port B.
    logic [DW-1:0] bram [2**AW];
    always @(posedge clk) begin
        if (wen_a) bram[addr_a] <= data_in_a;
        if (ren_b) data_out_b <= bram[addr_b];
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct packed {
        logic [DW-1:0] d;
        logic          last;
    } exp_t;

    exp_t          exp_q [$];
    logic [DW-1:0] got_q [$];
    logic [DW-1:0] tile_buf [NN];
    int            trans_ref [NN] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};

    bit            phase_load = 1'b1;
    int            acc_cnt = 0;
    int            exp_tiles = 0;
    int            issued = 0;
    int            popped = 0;
    bit            stalled_prev = 1'b0;
    bit            done_prev = 1'b0;
    logic [DW-1:0] prev_data;
    int            lat_k = 0;
    bit            lat_ren_pend = 1'b0;
    bit            lat_ov_pend = 1'b0;
    bit            hs, exp_wen, exp_last;
    exp_t          e;

    // Model: expected output is the transpose of each group of NN accepted inputs.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            phase_load   = 1'b1;
            acc_cnt      = 0;
            exp_tiles    = 0;
            issued       = 0;
            popped       = 0;
            stalled_prev = 1'b0;
            done_prev    = 1'b0;
            lat_ren_pend = 1'b0;
            lat_ov_pend  = 1'b0;
        end else begin
            hs      = out_valid && out_ready;
            exp_wen = phase_load && in_valid;
            check("in_ready", 32'(in_ready), 32'(phase_load));
            if (done_prev) check("in_ready_after_done", 32'(in_ready), 32'd1);
            check("wen_a", 32'(wen_a), 32'(exp_wen));
            if (exp_wen) begin
                check("addr_a", 32'(addr_a), 32'(acc_cnt));
                check("data_in_a", 32'(data_in_a), 32'(in_data));
            end
            check("tied_ports", 32'({ren_a, wen_b, data_in_b}), 32'd0);
            if (phase_load) begin
                check("ren_b_in_load", 32'(ren_b), 32'd0);
                check("out_valid_in_load", 32'(out_valid), 32'd0);
            end
            if (stalled_prev) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data", 32'(out_data), 32'(prev_data));
            end
            exp_last = 1'b0;
            if (hs) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    exp_last = e.last;
                    check("out_data", 32'(out_data), 32'(e.d));
                    check("out_last", 32'(out_last), 32'(e.last));
                    got_q.push_back(out_data);
                end
            end
            check("tile_done", 32'(tile_done), 32'(hs && exp_last));
            check("tiles_count", 32'(tiles_count), 32'(exp_tiles[15:0]));
            if (ren_b) issued++;
            if (hs) popped++;
            check("outstanding_le2", 32'((issued - popped) <= 2), 32'd1);
            if (lat_ren_pend && ren_b) begin
                check("lat_first_ren", 32'(cyc), 32'(lat_k + 1));
                lat_ren_pend = 1'b0;
            end
            if (lat_ov_pend && out_valid) begin
                check("lat_first_valid", 32'(cyc), 32'(lat_k + 3));
                lat_ov_pend = 1'b0;
            end
            if (exp_wen) begin
                tile_buf[acc_cnt] = in_data;
                acc_cnt++;
                if (acc_cnt == NN) begin
                    for (int c = 0; c < N; c++)
                        for (int r = 0; r < N; r++)
                            exp_q.push_back('{d: tile_buf[r*N+c], last: (c == N-1) && (r == N-1)});
                    acc_cnt      = 0;
                    phase_load   = 1'b0;
                    lat_k        = cyc;
                    lat_ren_pend = 1'b1;
                    lat_ov_pend  = 1'b1;
                end
            end
            if (hs && exp_last) begin
                phase_load = 1'b1;
                exp_tiles++;
            end
            stalled_prev = out_valid && !out_ready;
            prev_data    = out_data;
            done_prev    = tile_done;
        end
    end

    bit rnd_mode = 1'b0;
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_tile(input int base, input bit gaps);
        for (int i = 0; i < NN; i++) begin
            if (gaps && (i % 3 == 1)) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = 8'(base + i);
            wait_ready();
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_tiles(input int n);
        int t = 0;
        while (exp_tiles < n && t < 1000) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("tiles_count_after_tile", 32'(tiles_count), 32'(n));
    endtask

    task automatic check_tile(input int s, input int base, input int n);
        check("tile_len", 32'(got_q.size() >= s + n), 32'd1);
        for (int i = 0; i < n; i++)
            if (s + i < got_q.size())
                check("tile_elem", 32'(got_q[s+i]), 32'((base + trans_ref[i]) & 255));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int s, s2, t;
    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_tile_done", 32'(tile_done), 32'd0);
        check("rst_tiles_count", 32'(tiles_count), 32'd0);
        check("rst_wen_a", 32'(wen_a), 32'd0);
        check("rst_ren_b", 32'(ren_b), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        // Plain tile, output always ready.
        s = got_q.size();
        send_tile(0, 1'b0);
        wait_tiles(1);
        check_tile(s, 0, NN);

        // Random backpressure on the output.
        rnd_mode = 1'b1;
        s = got_q.size();
        send_tile(0, 1'b0);
        wait_tiles(2);
        check_tile(s, 0, NN);
        rnd_mode = 1'b0;

        // Input gaps, then in_valid held high through the drain.
        s = got_q.size();
        send_tile(64, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'hEE;
        wait_tiles(3);
        in_valid = 1'b0;
        check_tile(s, 64, NN);

        // Back-to-back tiles.
        s = got_q.size();
        send_tile(0, 1'b0);
        send_tile(100, 1'b0);
        wait_tiles(5);
        check_tile(s, 0, NN);
        check_tile(s + NN, 100, NN);

        // Reset in the middle of a drain.
        s = got_q.size();
        send_tile(50, 1'b0);
        t = 0;
        while (got_q.size() < s + 6 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        check_tile(s, 50, 6);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_tiles_count", 32'(tiles_count), 32'd0);
        s2 = got_q.size();
        send_tile(200, 1'b0);
        wait_tiles(1);
        check_tile(s2, 200, NN);

        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
